// File: rtl/led_cmd_ctrl.sv
// led_cmd_ctrl: decodes UART receive bytes into per-channel LED enable,
// PWM duty and blink state, with ack/err pulses and a mid-command timeout.
module led_cmd_ctrl #(
    parameter int CHANNELS  = 8,
    parameter int DUTY_BITS = 4,
    parameter int BLINK_DIV = 51_670_000,
    parameter int TIMEOUT   = 10_334_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] enable,
    output logic                cmd_ack,
    output logic                cmd_err
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TO_W = $clog2(TIMEOUT);
    localparam int BL_W = $clog2(BLINK_DIV);
    localparam logic [7:0]      CH_N   = 8'(CHANNELS);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);
    localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DUTY_CH,
        S_DUTY_VAL,
        S_BLINK_CH
    } state_t;

    state_t                state_reg, state_next;
    logic [CH_W-1:0]       ch_reg, ch_next;
    logic [TO_W-1:0]       to_cnt_reg, to_cnt_next;
    logic [CHANNELS-1:0]   enable_reg, enable_next;
    logic [CHANNELS-1:0]   blink_reg, blink_next;
    logic [DUTY_BITS-1:0]  duty_reg [CHANNELS];
    logic                  duty_we;
    logic [DUTY_BITS-1:0]  pwm_cnt_reg;
    logic [BL_W-1:0]       blink_cnt_reg;
    logic                  phase_reg;
    logic [CHANNELS-1:0]   led_reg, led_next;
    logic                  ack_reg, ack_next;
    logic                  err_reg, err_next;

    // Channel letter decode: upper case selects/turns on, lower case turns off.
    logic [7:0]      up_off, lo_off;
    logic            up_valid, lo_valid;
    logic [CH_W-1:0] up_idx, lo_idx;

    assign up_off   = rx_data - 8'h41;
    assign lo_off   = rx_data - 8'h61;
    assign up_valid = (rx_data >= 8'h41) && (up_off < CH_N);
    assign lo_valid = (rx_data >= 8'h61) && (lo_off < CH_N);
    assign up_idx   = up_off[CH_W-1:0];
    assign lo_idx   = lo_off[CH_W-1:0];

    assign led     = led_reg;
    assign enable  = enable_reg;
    assign cmd_ack = ack_reg;
    assign cmd_err = err_reg;

    // Next-state, command decode and timeout handling.
    always_comb begin
        state_next  = state_reg;
        ch_next     = ch_reg;
        to_cnt_next = to_cnt_reg;
        enable_next = enable_reg;
        blink_next  = blink_reg;
        duty_we     = 1'b0;
        ack_next    = 1'b0;
        err_next    = 1'b0;
        if (state_reg == S_IDLE) begin
            to_cnt_next = '0;
            if (rx_valid) begin
                if (up_valid) begin
                    enable_next[up_idx] = 1'b1;
                    ack_next            = 1'b1;
                end else if (lo_valid) begin
                    enable_next[lo_idx] = 1'b0;
                    ack_next            = 1'b1;
                end else if (rx_data == 8'h40) begin
                    enable_next = '1;
                    ack_next    = 1'b1;
                end else if (rx_data == 8'h60) begin
                    enable_next = '0;
                    blink_next  = '0;
                    ack_next    = 1'b1;
                end else if (rx_data == 8'h23) begin
                    state_next = S_DUTY_CH;
                end else if (rx_data == 8'h2A) begin
                    state_next = S_BLINK_CH;
                end else begin
                    err_next = 1'b1;
                end
            end
        end else if (rx_valid) begin
            // A byte always wins over a timeout expiring in the same cycle.
            to_cnt_next = '0;
            case (state_reg)
                S_DUTY_CH: begin
                    if (up_valid) begin
                        ch_next    = up_idx;
                        state_next = S_DUTY_VAL;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_DUTY_VAL: begin
                    duty_we    = 1'b1;
                    ack_next   = 1'b1;
                    state_next = S_IDLE;
                end
                default: begin
                    if (up_valid) begin
                        blink_next[up_idx] = ~blink_reg[up_idx];
                        ack_next           = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    state_next = S_IDLE;
                end
            endcase
        end else if (to_cnt_reg == TO_MAX) begin
            to_cnt_next = '0;
            err_next    = 1'b1;
            state_next  = S_IDLE;
        end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end
    end

    // Per-channel LED drive: enable, PWM compare and blink gating.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_led
            assign led_next[gi] = enable_reg[gi]
                                & (pwm_cnt_reg < duty_reg[gi])
                                & (~blink_reg[gi] | phase_reg);
        end
    endgenerate

    // FSM and command state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= S_IDLE;
            ch_reg     <= '0;
            to_cnt_reg <= '0;
            enable_reg <= '0;
            blink_reg  <= '0;
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ch_reg     <= ch_next;
            to_cnt_reg <= to_cnt_next;
            enable_reg <= enable_next;
            blink_reg  <= blink_next;
            ack_reg    <= ack_next;
            err_reg    <= err_next;
        end
    end

    // Duty registers; only the latched target channel is written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_reg[i] <= '1;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (duty_we && (ch_reg == CH_W'(i))) begin
                    duty_reg[i] <= rx_data[DUTY_BITS-1:0];
                end
            end
        end
    end

    // Free-running PWM counter, blink divider and blink phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_reg   <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b1;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            if (blink_cnt_reg == BL_MAX) begin
                blink_cnt_reg <= '0;
                phase_reg     <= ~phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    // Registered LED outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_reg <= '0;
        end else begin
            led_reg <= led_next;
        end
    end

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// tb_led_cmd_ctrl: table-driven decode checks plus directed PWM, blink,
// timeout and reset sequences for led_cmd_ctrl.
module tb_led_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] led, enable;
    logic       cmd_ack, cmd_err;

    int checks = 0;
    int errors = 0;

    led_cmd_ctrl #(
        .CHANNELS(8), .DUTY_BITS(2), .BLINK_DIV(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .led(led), .enable(enable), .cmd_ack(cmd_ack), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       err;
        logic [7:0] en;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // One byte strobe; returns ack/err as seen the cycle after consumption.
    task automatic send(input logic [7:0] b, output logic a, output logic e);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        a = cmd_ack;
        e = cmd_err;
    endtask

    task automatic count_led(input int ch, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            cnt += int'(led[ch]);
        end
    endtask

    // Ack and err must never be high together.
    always @(negedge clk) begin
        if (reset_n && cmd_ack && cmd_err) begin
            errors++;
            $display("FAIL ack_err_overlap actual=11 required=not both");
        end
    end

    initial begin
        logic a, e;
        int   cnt;

        vecs[0]  = '{8'h41, 1'b1, 1'b0, 8'h01};
        vecs[1]  = '{8'h43, 1'b1, 1'b0, 8'h05};
        vecs[2]  = '{8'h62, 1'b1, 1'b0, 8'h05};
        vecs[3]  = '{8'h40, 1'b1, 1'b0, 8'hFF};
        vecs[4]  = '{8'h60, 1'b1, 1'b0, 8'h00};
        vecs[5]  = '{8'h49, 1'b0, 1'b1, 8'h00};
        vecs[6]  = '{8'h55, 1'b0, 1'b1, 8'h00};
        vecs[7]  = '{8'h23, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{8'h7A, 1'b0, 1'b1, 8'h00};
        vecs[9]  = '{8'h41, 1'b1, 1'b0, 8'h01};
        vecs[10] = '{8'h61, 1'b1, 1'b0, 8'h00};
        vecs[11] = '{8'h48, 1'b1, 1'b0, 8'h80};
        vecs[12] = '{8'h68, 1'b1, 1'b0, 8'h00};
        vecs[13] = '{8'h2A, 1'b0, 1'b0, 8'h00};
        vecs[14] = '{8'h5A, 1'b0, 1'b1, 8'h00};
        vecs[15] = '{8'h50, 1'b0, 1'b1, 8'h00};

        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_led", 32'(led), 32'h00);
        chk("reset_enable", 32'(enable), 32'h00);
        chk("reset_ack", 32'(cmd_ack), 32'h0);
        chk("reset_err", 32'(cmd_err), 32'h0);
        reset_n = 1'b1;

        // Single-byte decode and error table.
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].data, a, e);
            chk($sformatf("vec%0d_%02h_ack", i, vecs[i].data), 32'(a), 32'(vecs[i].ack));
            chk($sformatf("vec%0d_%02h_err", i, vecs[i].data), 32'(e), 32'(vecs[i].err));
            chk($sformatf("vec%0d_%02h_en", i, vecs[i].data), 32'(enable), 32'(vecs[i].en));
        end

        // Back-to-back strobes on consecutive cycles.
        cnt = 0;
        @(negedge clk); rx_data = 8'h41; rx_valid = 1'b1;
        @(negedge clk); rx_data = 8'h42; cnt += int'(cmd_ack);
        @(negedge clk); rx_data = 8'h43; cnt += int'(cmd_ack);
        @(negedge clk); rx_valid = 1'b0; cnt += int'(cmd_ack);
        chk("b2b_acks", 32'(cnt), 32'd3);
        chk("b2b_enable", 32'(enable), 32'h07);

        // PWM duty on channel 0.
        send(8'h23, a, e); send(8'h41, a, e); send(8'h01, a, e);
        chk("duty1_ack", 32'(a), 32'h1);
        repeat (2) @(negedge clk);
        count_led(0, 16, cnt);
        chk("duty1_led0_of16", 32'(cnt), 32'd4);
        send(8'h23, a, e); send(8'h41, a, e); send(8'h00, a, e);
        repeat (2) @(negedge clk);
        count_led(0, 16, cnt);
        chk("duty0_led0_of16", 32'(cnt), 32'd0);
        send(8'h23, a, e); send(8'h41, a, e); send(8'h03, a, e);
        repeat (2) @(negedge clk);
        count_led(0, 16, cnt);
        chk("duty3_led0_of16", 32'(cnt), 32'd12);

        // Blink on channel 1 (duty 3 default).
        count_led(1, 32, cnt);
        chk("noblink_led1_of32", 32'(cnt), 32'd24);
        send(8'h2A, a, e);
        chk("blink_cmd1_noack", 32'(a), 32'h0);
        send(8'h42, a, e);
        chk("blink_on_ack", 32'(a), 32'h1);
        repeat (2) @(negedge clk);
        count_led(1, 32, cnt);
        chk("blink_led1_of32", 32'(cnt), 32'd12);
        count_led(0, 32, cnt);
        chk("blink_led0_untouched", 32'(cnt), 32'd24);
        send(8'h2A, a, e); send(8'h42, a, e);
        repeat (2) @(negedge clk);
        count_led(1, 32, cnt);
        chk("blink_off_led1_of32", 32'(cnt), 32'd24);
        send(8'h2A, a, e); send(8'h42, a, e);
        send(8'h60, a, e);
        chk("clear_all_enable", 32'(enable), 32'h00);
        send(8'h40, a, e);
        chk("set_all_enable", 32'(enable), 32'hFF);
        repeat (2) @(negedge clk);
        count_led(1, 32, cnt);
        chk("clear_all_unblinks_led1", 32'(cnt), 32'd24);

        // Timeout after 16 idle cycles in DUTY_CH.
        send(8'h60, a, e);
        send(8'h23, a, e);
        repeat (15) @(negedge clk);
        chk("timeout_not_early", 32'(cmd_err), 32'h0);
        @(negedge clk);
        chk("timeout_err", 32'(cmd_err), 32'h1);
        @(negedge clk);
        chk("timeout_err_one_cycle", 32'(cmd_err), 32'h0);
        send(8'h41, a, e);
        chk("after_timeout_ack", 32'(a), 32'h1);
        chk("after_timeout_enable", 32'(enable), 32'h01);

        // Byte arriving exactly when the timeout would fire is accepted.
        send(8'h23, a, e);
        repeat (14) @(negedge clk);
        send(8'h41, a, e);
        chk("edge_byte_no_err", 32'(e), 32'h0);
        send(8'h02, a, e);
        chk("edge_duty_ack", 32'(a), 32'h1);
        chk("edge_duty_no_err", 32'(e), 32'h0);
        repeat (2) @(negedge clk);
        count_led(0, 16, cnt);
        chk("edge_duty2_led0_of16", 32'(cnt), 32'd8);

        // Reset in the middle of a duty command.
        send(8'h23, a, e); send(8'h41, a, e); send(8'h01, a, e);
        repeat (2) @(negedge clk);
        count_led(0, 16, cnt);
        chk("pre_reset_duty1", 32'(cnt), 32'd4);
        send(8'h23, a, e); send(8'h41, a, e);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_led", 32'(led), 32'h00);
        chk("midreset_enable", 32'(enable), 32'h00);
        chk("midreset_err", 32'(cmd_err), 32'h0);
        reset_n = 1'b1;
        send(8'h02, a, e);
        chk("post_reset_02_err", 32'(e), 32'h1);
        chk("post_reset_02_noack", 32'(a), 32'h0);
        send(8'h41, a, e);
        chk("post_reset_enable", 32'(enable), 32'h01);
        repeat (2) @(negedge clk);
        count_led(0, 16, cnt);
        chk("post_reset_duty3", 32'(cnt), 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_cmd_ctrl.md
# led_cmd_ctrl

Parametrised LED command controller for the badge. It decodes a stream of UART receive bytes into per-channel LED state: on/off, PWM brightness and blink. It sits between `uart_top`'s receive path and the `led` pins, and generalises the fixed 8-cat on/off decoder to N channels. Over that decoder it adds multi-byte commands, PWM duty per channel, blink mode, error reporting and a mid-command timeout.

## Interface
Parameters:
- `CHANNELS`, 8 — number of LED channels; legal range 1..26.
- `DUTY_BITS`, 4 — PWM resolution; legal range 1..8; the PWM period is 2^DUTY_BITS cycles.
- `BLINK_DIV`, 51_670_000 — clk cycles per blink half-period; must be ≥ 2.
- `TIMEOUT`, 10_334_000 — idle clk cycles allowed between bytes of one command; must be ≥ 2.

Ports (all registered outputs):
- `clk` — input, 1 — system clock.
- `reset_n` — input, 1 — asynchronous, active-low reset.
- `rx_data` — input, 8 — received byte.
- `rx_valid` — input, 1 — one-cycle strobe; `rx_data` is valid in that cycle.
- `led` — output, CHANNELS — LED drive, active-high.
- `enable` — output, CHANNELS — per-channel on/off status.
- `cmd_ack` — output, 1 — one-cycle pulse when a command completes.
- `cmd_err` — output, 1 — one-cycle pulse when a command is rejected or times out.

## Operation
Register values while `reset_n` = 0:
- `enable` = 0, every duty = 2^DUTY_BITS−1, every blink bit = 0.
- PWM counter = 0, blink counter = 0, blink phase = 1.
- FSM = IDLE, timeout counter = 0.
- `led`, `cmd_ack`, `cmd_err` = 0.

Channel letter: `L` = 0x41+i, where i < CHANNELS. Any other value is an invalid channel.

FSM states: IDLE, DUTY_CH, DUTY_VAL, BLINK_CH. In IDLE, each byte is handled as follows:
- 0x41+i, i < CHANNELS: `enable[i]` ← 1; ack.
- 0x61+i, i < CHANNELS: `enable[i]` ← 0; ack.
- 0x40 (`@`): all enable bits ← 1; ack.
- 0x60 (`` ` ``): all enable bits ← 0 and all blink bits ← 0; ack.
- 0x23 (`#`): go to DUTY_CH.
- 0x2A (`*`): go to BLINK_CH.
- Any other byte, including an out-of-range letter: err; stay in IDLE.

Multi-byte states:
- DUTY_CH: a valid `L` latches the channel and goes to DUTY_VAL. An invalid byte gives err and returns to IDLE.
- DUTY_VAL: any byte sets duty[ch] ← `rx_data[DUTY_BITS-1:0]`; ack; return to IDLE.
- BLINK_CH: a valid `L` toggles blink[ch]; ack; IDLE. An invalid byte gives err and returns to IDLE.

Timeout:
- Applies in every non-IDLE state.
- The counter clears on every accepted byte and increments every cycle with no `rx_valid`.
- When it reaches TIMEOUT−1, the FSM returns to IDLE and `cmd_err` pulses.
- A byte arriving in that same cycle is taken as the command's next byte; the timeout does not fire.

PWM and blink:
- The PWM counter is DUTY_BITS wide and free-running, wrapping to 0.
- `pwm_on[i]` = (cnt < duty[i]). Duty 0 is always off. The maximum duty is on for 2^DUTY_BITS−1 of every 2^DUTY_BITS cycles.
- The blink counter counts 0..BLINK_DIV−1. At wrap, the blink phase toggles.
- `led[i]` ← `enable[i]` & `pwm_on[i]` & (~blink[i] | phase).

Commands never touch channels other than their target.

## Timing
- A byte is consumed on the clk edge where `rx_valid` = 1. There is no backpressure, and back-to-back strobes on consecutive cycles must be accepted.
- `enable`, duty and blink update on that edge. `enable` is visible 1 cycle after the strobe; `led` reflects the change 2 cycles after it.
- `cmd_ack` and `cmd_err` are high in the cycle after the completing or offending edge, for exactly 1 cycle. They are never high together.
- Asserting `reset_n` mid-command clears all state immediately. The partial command is discarded without `cmd_err`.
- Timeout error: `cmd_err` is high in the cycle after the FSM returns to IDLE.

## Test plan
All directed tests use CHANNELS=8, DUTY_BITS=2, BLINK_DIV=4, TIMEOUT=16.
1. Bytes 0x41, 0x43, 0x62 → `enable` = 0x05; 3 `cmd_ack` pulses. Then 0x40 → 0xFF, then 0x60 → 0x00.
2. Bytes 0x23, 0x41, 0x01 with `enable[0]` = 1 → `led[0]` high 1 of every 4 cycles. Duty 0 → `led[0]` never high. Duty 3 → `led[0]` high 3 of every 4 cycles.
3. Bytes 0x2A, 0x42 with `enable[1]` = 1 and duty 3 → the PWM pattern on `led[1]` is gated on for 4 cycles, off for 4, repeating. Sending 0x2A, 0x42 again → blink off.
4. Invalid input → each case gives 1 `cmd_err`, no state change, FSM back in IDLE:
   - 0x49 (channel 8, out of range).
   - 0x23 followed by 0x7A.
   - 0x55 in IDLE.
5. Byte 0x23, then 16 idle cycles → `cmd_err` pulse. A following 0x41 is then decoded as a channel-0 on command, not as a duty channel.
6. Byte 0x23, 0x41, then `reset_n` low for 1 cycle, then 0x02 → `reset_n` low clears all outputs and restores default duty. After reset, the 0x02 byte yields only `cmd_err`; duty[0] stays 3.
